hazard_control_unit: RTL and testbench

- Pipeline sequencing controller for the 5-stage RISC-V core; companion to the forwarding logic.
- Resolves what forwarding cannot: memory wait states, multi-cycle MUL/DIV occupancy of EX, load-use hazards, ID-stage branch-compare hazards, and taken-branch flushes.
- Drives per-stage write-enable/flush controls for PC, IF/ID, ID/EX, EX/MEM and MEM/WB, and keeps saturating stall/flush performance counters.

---
 rtl/hazard_control_unit_pkg.sv | 27 ++
 rtl/hazard_control_unit_if.sv | 53 +++++
 rtl/hazard_perf_counter.sv | 37 +++
 rtl/hazard_control_unit.sv | 117 +++++++++++
 tb/tb_hazard_control_unit.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/hazard_control_unit_pkg.sv
// ============================================================================
// Module   : hazard_pkg
// Brief    : Shared types and constants for the pipeline hazard controller.
// Revision : 1.0
// ============================================================================
`default_nettype none

package hazard_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MDU_BUSY = 2'd1,
        MDU_DONE = 2'd2
    } hz_state_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // True when a producer register is live and feeds either ID source operand.
    function automatic logic src_match(input logic [4:0] rd,
                                       input logic [4:0] rs1,
                                       input logic [4:0] rs2);
        return (rd != REG_ZERO) && ((rd == rs1) || (rd == rs2));
    endfunction

endpackage

`default_nettype wire

// File: rtl/hazard_control_unit_if.sv
// ============================================================================
// Module   : hazard_control_unit_if
// Brief    : Pipeline-status inputs and stage-control outputs of the hazard unit.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface hazard_control_unit_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       IF_ID_RS_i;
    logic [4:0]       IF_ID_RT_i;
    logic             ID_branch_i;
    logic             ID_branch_taken_i;
    logic [4:0]       ID_EX_RD_i;
    logic             ID_EX_RegWrite_i;
    logic             ID_EX_MemR_i;
    logic             ID_EX_mdu_i;
    logic [4:0]       EX_MEM_RD_i;
    logic             EX_MEM_MemR_i;
    logic             EX_MEM_MemW_i;
    logic             mem_ready_i;
    logic             PC_write_o;
    logic             IF_ID_write_o;
    logic             IF_ID_flush_o;
    logic             ID_EX_write_o;
    logic             ID_EX_flush_o;
    logic             EX_MEM_write_o;
    logic             EX_MEM_flush_o;
    logic             MEM_WB_write_o;
    logic [CNT_W-1:0] stall_cnt_o;
    logic [CNT_W-1:0] flush_cnt_o;

    modport master (
        output IF_ID_RS_i, IF_ID_RT_i, ID_branch_i, ID_branch_taken_i,
               ID_EX_RD_i, ID_EX_RegWrite_i, ID_EX_MemR_i, ID_EX_mdu_i,
               EX_MEM_RD_i, EX_MEM_MemR_i, EX_MEM_MemW_i, mem_ready_i,
        input  PC_write_o, IF_ID_write_o, IF_ID_flush_o, ID_EX_write_o,
               ID_EX_flush_o, EX_MEM_write_o, EX_MEM_flush_o, MEM_WB_write_o,
               stall_cnt_o, flush_cnt_o
    );

    modport slave (
        input  IF_ID_RS_i, IF_ID_RT_i, ID_branch_i, ID_branch_taken_i,
               ID_EX_RD_i, ID_EX_RegWrite_i, ID_EX_MemR_i, ID_EX_mdu_i,
               EX_MEM_RD_i, EX_MEM_MemR_i, EX_MEM_MemW_i, mem_ready_i,
        output PC_write_o, IF_ID_write_o, IF_ID_flush_o, ID_EX_write_o,
               ID_EX_flush_o, EX_MEM_write_o, EX_MEM_flush_o, MEM_WB_write_o,
               stall_cnt_o, flush_cnt_o
    );
endinterface

`default_nettype wire

// File: rtl/hazard_perf_counter.sv
// ============================================================================
// Module   : hazard_perf_counter
// Brief    : Event counter that sticks at all-ones instead of wrapping.
// Revision : 1.0
// ============================================================================
`default_nettype none

module hazard_perf_counter #(
    parameter int W = 32
) (
    input  wire logic         clk_i,
    input  wire logic         rst_i,
    input  wire logic         inc_i,
    output logic [W-1:0]      cnt_o
);
    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
endmodule

`default_nettype wire

// File: rtl/hazard_control_unit.sv
// ============================================================================
// Module   : hazard_control_unit
// Brief    : Stage enable/flush sequencing for the 5-stage pipeline.
// Revision : 1.0
// ============================================================================
`default_nettype none

module hazard_control_unit
    import hazard_pkg::*;
#(
    parameter int MDU_LATENCY = 4,
    parameter int CNT_W       = 32
) (
    input  wire logic             clk_i,
    input  wire logic             rst_i,
    hazard_control_unit_if.slave  hz
);
    localparam int MC_W = $clog2(MDU_LATENCY);
    localparam logic [MC_W-1:0] MDU_CNT_INIT = MC_W'(MDU_LATENCY - 2);

    hz_state_e       state_q, state_d;
    logic [MC_W-1:0] mdu_cnt_q, mdu_cnt_d;

    logic mem_wait, mdu_freeze, load_use, br_haz;

    assign mem_wait   = (hz.EX_MEM_MemR_i || hz.EX_MEM_MemW_i) && !hz.mem_ready_i;
    assign mdu_freeze = ((state_q == RUN) && hz.ID_EX_mdu_i) || (state_q == MDU_BUSY);
    assign load_use   = hz.ID_EX_MemR_i &&
                        src_match(hz.ID_EX_RD_i, hz.IF_ID_RS_i, hz.IF_ID_RT_i);
    // A load still in MEM cannot be forwarded into the ID comparator yet.
    assign br_haz     = hz.ID_branch_i &&
                        ((hz.ID_EX_RegWrite_i &&
                          src_match(hz.ID_EX_RD_i, hz.IF_ID_RS_i, hz.IF_ID_RT_i)) ||
                         (hz.EX_MEM_MemR_i &&
                          src_match(hz.EX_MEM_RD_i, hz.IF_ID_RS_i, hz.IF_ID_RT_i)));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= RUN;
            mdu_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            mdu_cnt_q <= mdu_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        mdu_cnt_d = mdu_cnt_q;
        if (!mem_wait) begin
            case (state_q)
                RUN: begin
                    if (hz.ID_EX_mdu_i) begin
                        state_d   = MDU_BUSY;
                        mdu_cnt_d = MDU_CNT_INIT;
                    end
                end
                MDU_BUSY: begin
                    if (mdu_cnt_q == '0) begin
                        state_d = MDU_DONE;
                    end else begin
                        mdu_cnt_d = mdu_cnt_q - 1'b1;
                    end
                end
                MDU_DONE: state_d = RUN;
                default:  state_d = RUN;
            endcase
        end
    end

    always_comb begin
        hz.PC_write_o     = 1'b1;
        hz.IF_ID_write_o  = 1'b1;
        hz.IF_ID_flush_o  = 1'b0;
        hz.ID_EX_write_o  = 1'b1;
        hz.ID_EX_flush_o  = 1'b0;
        hz.EX_MEM_write_o = 1'b1;
        hz.EX_MEM_flush_o = 1'b0;
        hz.MEM_WB_write_o = 1'b1;
        if (rst_i) begin
            // Reset forces the free-running defaults regardless of inputs.
        end else if (mem_wait) begin
            hz.PC_write_o     = 1'b0;
            hz.IF_ID_write_o  = 1'b0;
            hz.ID_EX_write_o  = 1'b0;
            hz.EX_MEM_write_o = 1'b0;
            hz.MEM_WB_write_o = 1'b0;
        end else if (mdu_freeze) begin
            hz.PC_write_o     = 1'b0;
            hz.IF_ID_write_o  = 1'b0;
            hz.ID_EX_write_o  = 1'b0;
            hz.EX_MEM_flush_o = 1'b1;
        end else if (load_use || br_haz) begin
            hz.PC_write_o     = 1'b0;
            hz.IF_ID_write_o  = 1'b0;
            hz.ID_EX_flush_o  = 1'b1;
        end else if (hz.ID_branch_taken_i) begin
            hz.IF_ID_flush_o  = 1'b1;
        end
    end

    hazard_perf_counter #(.W(CNT_W)) u_stall_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (!hz.PC_write_o),
        .cnt_o (hz.stall_cnt_o)
    );

    hazard_perf_counter #(.W(CNT_W)) u_flush_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (hz.IF_ID_flush_o),
        .cnt_o (hz.flush_cnt_o)
    );
endmodule

`default_nettype wire

// File: tb/tb_hazard_control_unit.sv
// ============================================================================
// Module   : tb_hazard_control_unit
// Brief    : Directed bench for hazard_control_unit (MDU_LATENCY=4, CNT_W=4).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_hazard_control_unit;
    localparam int CNT_W = 4;

    // Control word order: PCw, IFIDw, IFIDf, IDEXw, IDEXf, EXMEMw, EXMEMf, MEMWBw
    localparam logic [7:0] C_NORM  = 8'b1101_0101;
    localparam logic [7:0] C_WAIT  = 8'b0000_0000;
    localparam logic [7:0] C_MDU   = 8'b0000_0111;
    localparam logic [7:0] C_STALL = 8'b0001_1101;
    localparam logic [7:0] C_TAKEN = 8'b1111_0101;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    hazard_control_unit_if #(.CNT_W(CNT_W)) bus ();

    hazard_control_unit #(.MDU_LATENCY(4), .CNT_W(CNT_W)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .hz    (bus)
    );

    always #5 clk = ~clk;

    logic [7:0] ctrl;
    assign ctrl = {bus.PC_write_o, bus.IF_ID_write_o, bus.IF_ID_flush_o,
                   bus.ID_EX_write_o, bus.ID_EX_flush_o, bus.EX_MEM_write_o,
                   bus.EX_MEM_flush_o, bus.MEM_WB_write_o};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.IF_ID_RS_i        = 5'd0;
        bus.IF_ID_RT_i        = 5'd0;
        bus.ID_branch_i       = 1'b0;
        bus.ID_branch_taken_i = 1'b0;
        bus.ID_EX_RD_i        = 5'd0;
        bus.ID_EX_RegWrite_i  = 1'b0;
        bus.ID_EX_MemR_i      = 1'b0;
        bus.ID_EX_mdu_i       = 1'b0;
        bus.EX_MEM_RD_i       = 5'd0;
        bus.EX_MEM_MemR_i     = 1'b0;
        bus.EX_MEM_MemW_i     = 1'b0;
        bus.mem_ready_i       = 1'b1;
    endtask

    initial begin
        idle();
        #1;
        chk("rst_ctrl", 32'(ctrl), 32'(C_NORM));
        chk("rst_stall_cnt", 32'(bus.stall_cnt_o), 0);
        tick();
        rst = 1'b0;
        #1;
        chk("post_rst_ctrl", 32'(ctrl), 32'(C_NORM));

        // Load-use on rs1
        bus.ID_EX_MemR_i = 1'b1; bus.ID_EX_RD_i = 5'd5; bus.IF_ID_RS_i = 5'd5;
        #1 chk("load_use", 32'(ctrl), 32'(C_STALL));
        tick();
        chk("load_use_cnt", 32'(bus.stall_cnt_o), 1);
        idle();
        bus.ID_EX_MemR_i = 1'b1;
        #1 chk("load_use_x0", 32'(ctrl), 32'(C_NORM));
        tick();
        chk("load_use_x0_cnt", 32'(bus.stall_cnt_o), 1);

        // Branch fed by a load: P3 with load in EX, then P4 with load in MEM
        idle();
        bus.ID_branch_i = 1'b1; bus.IF_ID_RS_i = 5'd7;
        bus.ID_EX_MemR_i = 1'b1; bus.ID_EX_RegWrite_i = 1'b1; bus.ID_EX_RD_i = 5'd7;
        #1 chk("br_load_ex", 32'(ctrl), 32'(C_STALL));
        tick();
        bus.ID_EX_MemR_i = 1'b0; bus.ID_EX_RegWrite_i = 1'b0; bus.ID_EX_RD_i = 5'd0;
        bus.EX_MEM_MemR_i = 1'b1; bus.EX_MEM_RD_i = 5'd7;
        #1 chk("br_load_mem", 32'(ctrl), 32'(C_STALL));
        tick();
        bus.EX_MEM_MemR_i = 1'b0; bus.EX_MEM_RD_i = 5'd0;
        #1 chk("br_load_clear", 32'(ctrl), 32'(C_NORM));
        chk("br_load_cnt", 32'(bus.stall_cnt_o), 3);

        // ALU producer on rs2 with taken branch: stall wins over flush
        bus.IF_ID_RS_i = 5'd0; bus.IF_ID_RT_i = 5'd7; bus.ID_branch_taken_i = 1'b1;
        bus.ID_EX_RegWrite_i = 1'b1; bus.ID_EX_RD_i = 5'd7;
        #1 chk("br_alu", 32'(ctrl), 32'(C_STALL));
        tick();
        bus.ID_EX_RegWrite_i = 1'b0; bus.ID_EX_RD_i = 5'd0;
        #1 chk("br_taken", 32'(ctrl), 32'(C_TAKEN));
        chk("br_alu_cnt", 32'(bus.stall_cnt_o), 4);
        chk("flush_cnt_pre", 32'(bus.flush_cnt_o), 0);
        tick();
        idle();
        #1 chk("after_taken", 32'(ctrl), 32'(C_NORM));
        chk("flush_cnt", 32'(bus.flush_cnt_o), 1);
        tick();
        chk("flush_cnt_hold", 32'(bus.flush_cnt_o), 1);

        // MDU op: 4 frozen cycles, then MDU_DONE ignores the still-high flag
        bus.ID_EX_mdu_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1 chk($sformatf("mdu_frz%0d", i), 32'(ctrl), 32'(C_MDU));
            tick();
        end
        #1 chk("mdu_done", 32'(ctrl), 32'(C_NORM));
        tick();
        bus.ID_EX_mdu_i = 1'b0;
        #1 chk("mdu_no_retrig", 32'(ctrl), 32'(C_NORM));
        chk("mdu_stall_cnt", 32'(bus.stall_cnt_o), 8);

        // MDU with a 3-cycle memory wait during MDU_BUSY: 7-cycle freeze
        bus.ID_EX_mdu_i = 1'b1;
        #1 chk("mw_detect", 32'(ctrl), 32'(C_MDU));
        tick();
        bus.EX_MEM_MemW_i = 1'b1; bus.mem_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1 chk($sformatf("mw_wait%0d", i), 32'(ctrl), 32'(C_WAIT));
            tick();
        end
        bus.EX_MEM_MemW_i = 1'b0; bus.mem_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 chk($sformatf("mw_busy%0d", i), 32'(ctrl), 32'(C_MDU));
            tick();
        end
        #1 chk("mw_done", 32'(ctrl), 32'(C_NORM));
        chk("mw_stall_cnt", 32'(bus.stall_cnt_o), 15);
        tick();
        bus.ID_EX_mdu_i = 1'b0;

        // Async reset in the middle of MDU_BUSY, with a load-use also present
        bus.ID_EX_mdu_i = 1'b1;
        tick();
        tick();
        bus.ID_EX_mdu_i = 1'b0;
        #1 chk("busy_before_rst", 32'(ctrl), 32'(C_MDU));
        bus.ID_EX_MemR_i = 1'b1; bus.ID_EX_RD_i = 5'd3; bus.IF_ID_RS_i = 5'd3;
        rst = 1'b1;
        #1 chk("mid_rst_ctrl", 32'(ctrl), 32'(C_NORM));
        chk("mid_rst_stall", 32'(bus.stall_cnt_o), 0);
        chk("mid_rst_flush", 32'(bus.flush_cnt_o), 0);
        tick();
        rst = 1'b0;
        idle();
        #1 chk("rst_to_run", 32'(ctrl), 32'(C_NORM));
        tick();
        chk("rst_to_run_cnt", 32'(bus.stall_cnt_o), 0);

        // Saturation: 20 stalled cycles on a 4-bit counter
        bus.ID_EX_MemR_i = 1'b1; bus.ID_EX_RD_i = 5'd9; bus.IF_ID_RT_i = 5'd9;
        for (int i = 0; i < 14; i++) tick();
        chk("sat_14", 32'(bus.stall_cnt_o), 14);
        for (int i = 0; i < 6; i++) tick();
        chk("sat_20", 32'(bus.stall_cnt_o), 15);
        tick();
        chk("sat_hold", 32'(bus.stall_cnt_o), 15);
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule

`default_nettype wire
